// File: rtl/cp_insert_stream.sv
// Cyclic-prefix inserter: buffers one N-sample symbol in RAM, then streams its last CP samples
// followed by all N samples. Two-stage read pipeline (RAM read register + output register) so
// the output never bubbles while m_ready is high and holds steady while stalled.
module cp_insert_stream #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LOG2_N_MAX = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOG2_N_MAX:0]   frame_length,
    input  logic [LOG2_N_MAX:0]   cp_length,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_cp,
    output logic                  m_last,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned CW    = LOG2_N_MAX + 1;
    localparam int unsigned Depth = 2 ** LOG2_N_MAX;
    localparam logic [CW-1:0] NMax = CW'(Depth);
    localparam logic [CW-1:0] One  = CW'(1);

    typedef enum logic [1:0] {StIdle, StFill, StCp, StBody} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0] mem_q [0:Depth-1];

    logic [CW-1:0]     n_q, cp_q, start_q, wr_cnt_q, rd_addr_q;
    logic              issue_done_q;
    logic              s1_valid_q, s1_cp_q, s1_last_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              m_valid_q, m_cp_q, m_last_q, error_q;
    logic [DATA_W-1:0] m_data_q;

    logic cfg_legal, wr_en, wr_last, out_ready, s1_free, issue, rd_end, m_last_xfer;

    assign cfg_legal   = (frame_length >= CW'(2)) && (frame_length <= NMax) &&
                         (cp_length < frame_length);
    assign wr_en       = (state_q == StFill) && s_valid;
    assign wr_last     = wr_en && (wr_cnt_q == n_q - One);
    assign out_ready   = !m_valid_q || m_ready;
    assign s1_free     = !s1_valid_q || out_ready;
    assign rd_end      = (rd_addr_q == n_q - One);
    assign issue       = ((state_q == StCp) || ((state_q == StBody) && !issue_done_q)) && s1_free;
    assign m_last_xfer = m_valid_q && m_ready && m_last_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; BODY is left only once the final beat has actually transferred
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_legal)         state_d = StFill;
            StFill:  if (wr_last)           state_d = (cp_q != '0) ? StCp : StBody;
            StCp:    if (issue && rd_end)   state_d = StBody;
            StBody:  if (m_last_xfer)       state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        s_ready = (state_q == StFill);
        busy    = (state_q != StIdle);
    end

    // Sample RAM: write port from FILL, registered read port feeding stage 1
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_cnt_q[LOG2_N_MAX-1:0]] <= s_data;
        if (issue) s1_data_q <= mem_q[rd_addr_q[LOG2_N_MAX-1:0]];
    end

    // Config latch, counters and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q          <= '0;
            cp_q         <= '0;
            start_q      <= '0;
            wr_cnt_q     <= '0;
            rd_addr_q    <= '0;
            issue_done_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if ((state_q == StIdle) && cfg_legal) begin
                n_q          <= frame_length;
                cp_q         <= cp_length;
                start_q      <= frame_length - cp_length;
                wr_cnt_q     <= '0;
                issue_done_q <= 1'b0;
            end
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + One;
                if (wr_last) rd_addr_q <= (cp_q != '0) ? start_q : '0;
            end
            if (issue) begin
                // Prefix ends at N-1, then the body restarts from address 0
                if ((state_q == StCp) && rd_end) rd_addr_q <= '0;
                else                             rd_addr_q <= rd_addr_q + One;
                if ((state_q == StBody) && rd_end) issue_done_q <= 1'b1;
            end
            // Level while config is illegal in IDLE; one-cycle pulse on s_last disagreement
            error_q <= ((state_q == StIdle) && !cfg_legal) || (wr_en && (s_last != wr_last));
        end
    end

    // Stage 1 (RAM read register) and output register with backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_cp_q    <= 1'b0;
            s1_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_cp_q     <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            if (issue) begin
                s1_valid_q <= 1'b1;
                s1_cp_q    <= (state_q == StCp);
                s1_last_q  <= (state_q == StBody) && rd_end;
            end else if (out_ready) begin
                s1_valid_q <= 1'b0;
            end
            if (out_ready) begin
                m_valid_q <= s1_valid_q;
                m_cp_q    <= s1_valid_q && s1_cp_q;
                m_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) m_data_q <= s1_data_q;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_cp    = m_cp_q;
    assign m_last  = m_last_q;
    assign error   = error_q;

endmodule

// File: tb/tb_cp_insert_stream.sv
// Self-checking bench for cp_insert_stream: config legality table, directed symbols, mid-symbol
// reset and randomized symbols checked against a queue-based reference of the output stream.
module tb_cp_insert_stream;

    localparam int DW = 32;
    localparam int LN = 10;
    localparam int CW = LN + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] frame_length, cp_length;
    logic [DW-1:0] s_data, m_data;
    logic          s_valid, s_last, s_ready, m_valid, m_ready, m_cp, m_last, busy, error;

    cp_insert_stream #(.DATA_W(DW), .LOG2_N_MAX(LN)) dut (
        .clk(clk), .rst(rst), .frame_length(frame_length), .cp_length(cp_length),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_cp(m_cp),
        .m_last(m_last), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] d; logic c; logic l;} beat_t;
    typedef struct {int fl; int cl; logic e; logic r; logic b;} cfg_vec_t;

    beat_t    exp_q[$];
    cfg_vec_t vt[10];

    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, wr_cyc = 0, fv_cyc = 0, err_pulses = 0;
    bit   acc, seen_valid, rnd_ready, prev_stall;
    logic [DW+1:0] hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: observe on the falling edge, then drive m_ready just after the rising edge
    task automatic tick();
        beat_t e;
        @(negedge clk);
        cyc++;
        acc = s_valid && s_ready;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {m_valid, m_data, m_cp, m_last}, {1'b1, hold});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {m_data, m_cp, m_last}, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_data, m_cp, m_last}, {e.d, e.c, e.l});
                end
            end
            prev_stall = m_valid && !m_ready;
            hold = {m_data, m_cp, m_last};
            if (m_valid && !seen_valid) begin
                seen_valid = 1'b1;
                fv_cyc = cyc;
            end
            if (busy && error) err_pulses++;
        end
        @(posedge clk);
        #1;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {s_ready, m_valid, m_cp, m_last, busy, error, m_data}, '0);
    endtask

    // Push one symbol and drain it; the expected stream is the tail slice then the whole symbol
    task automatic run_symbol(input int n, input int cp, input bit seq, input int extra_last,
                              input bit gaps, input bit abort);
        logic [DW-1:0] x[$];
        int guard;
        bit aborted = 1'b0;
        for (int i = 0; i < n; i++) x.push_back(seq ? DW'(i + 1) : DW'($urandom));
        for (int i = n - cp; i < n; i++) exp_q.push_back('{x[i], 1'b1, 1'b0});
        for (int i = 0; i < n; i++) exp_q.push_back('{x[i], 1'b0, i == n - 1});
        frame_length = CW'(n);
        cp_length    = CW'(cp);
        seen_valid   = 1'b0;
        err_pulses   = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                tick();
            end
            s_data  = x[i];
            s_last  = (i == n - 1) || (i + 1 == extra_last);
            s_valid = 1'b1;
            guard   = 0;
            do begin
                tick();
                guard++;
            end while (!acc && guard < 5000);
            if (!acc) chk("push_timeout", 64'(i), 64'(n));
            if (i == n - 1) wr_cyc = cyc;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        frame_length = '0;  // park illegal so the block idles after this symbol
        guard = 0;
        while (busy && guard < 20000) begin
            tick();
            guard++;
            if (abort && !aborted && m_valid && !m_cp) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("async_reset_outputs");
                exp_q.delete();
                aborted = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        chk("drain_timeout", 64'(busy), 64'(0));
        chk("beats_missing", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        vt[0] = '{8,    8,    1'b1, 1'b0, 1'b0};
        vt[1] = '{8,    2,    1'b0, 1'b1, 1'b1};
        vt[2] = '{1,    0,    1'b1, 1'b0, 1'b0};
        vt[3] = '{2,    1,    1'b0, 1'b1, 1'b1};
        vt[4] = '{2,    2,    1'b1, 1'b0, 1'b0};
        vt[5] = '{1024, 1023, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1025, 0,    1'b1, 1'b0, 1'b0};
        vt[7] = '{0,    0,    1'b1, 1'b0, 1'b0};
        vt[8] = '{8,    0,    1'b0, 1'b1, 1'b1};
        vt[9] = '{2047, 3,    1'b1, 1'b0, 1'b0};

        rst = 1'b1; frame_length = '0; cp_length = '0; s_data = '0;
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; rnd_ready = 1'b0;
        prev_stall = 1'b0; hold = '0; seen_valid = 1'b0;
        #12;
        chk_all_zero("reset_outputs");

        // Config legality table
        foreach (vt[k]) begin
            rst = 1'b1;
            frame_length = CW'(vt[k].fl);
            cp_length    = CW'(vt[k].cl);
            tick();
            rst = 1'b0;
            tick();
            tick();
            chk($sformatf("cfg_%0d_%0d", vt[k].fl, vt[k].cl), {error, s_ready, busy},
                {vt[k].e, vt[k].r, vt[k].b});
        end
        rst = 1'b1;
        frame_length = '0;
        tick();
        rst = 1'b0;

        // CP == N rejected, then corrected config runs a normal symbol
        frame_length = 8; cp_length = 8;
        repeat (3) tick();
        chk("cp_eq_n_reject", {error, s_ready, busy}, 3'b100);
        run_symbol(8, 2, 1'b1, 0, 1'b0, 1'b0);
        chk("latency_n8_cp2", 64'(fv_cyc - wr_cyc), 64'(3));
        chk("no_err_n8_cp2", 64'(err_pulses), 64'(0));

        // Same frame with random backpressure
        rnd_ready = 1'b1;
        run_symbol(8, 2, 1'b1, 0, 1'b0, 1'b0);
        rnd_ready = 1'b0;
        m_ready = 1'b1;

        // No prefix
        run_symbol(8, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("latency_n8_cp0", 64'(fv_cyc - wr_cyc), 64'(3));

        // Early s_last on sample 5: exactly one error pulse, symbol still full length
        run_symbol(8, 2, 1'b1, 5, 1'b0, 1'b0);
        chk("slast_pulse", 64'(err_pulses), 64'(1));

        // Largest symbol
        run_symbol(1024, 256, 1'b0, 0, 1'b0, 1'b0);

        // Reset mid-body, then a clean symbol
        run_symbol(8, 2, 1'b1, 0, 1'b0, 1'b1);
        run_symbol(8, 2, 1'b1, 0, 1'b0, 1'b0);

        // Randomized symbols with gaps and backpressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(2, 64);
            run_symbol(n, $urandom_range(0, n - 1), 1'b0, 0, 1'b1, 1'b0);
        end
        rnd_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
